// File: rtl/lcd_pkg.sv
// Shared types, init ROM contents and command decode for the HD44780 write sequencer.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PWRUP,
        ST_LOAD,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_EXEC
    } state_t;

    typedef struct packed {
        logic       rs;
        logic [7:0] db;
    } lcd_write_t;

    localparam int unsigned INIT_LEN = 6;
    localparam int unsigned IDX_W    = 3;

    localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME     = 8'h02;
    localparam logic [7:0] LCD_CMD_HOME_ALT = 8'h03;

    // 8-bit/2-line function set (x3), display on, entry mode, clear
    function automatic logic [7:0] init_byte(input logic [IDX_W-1:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: return 8'h38;
            3'd3:             return 8'h0C;
            3'd4:             return 8'h06;
            default:          return LCD_CMD_CLEAR;
        endcase
    endfunction

    // Clear and home need the long execution wait
    function automatic logic is_long_exec(input logic rs, input logic [7:0] db);
        return !rs && (db == LCD_CMD_CLEAR || db == LCD_CMD_HOME || db == LCD_CMD_HOME_ALT);
    endfunction

endpackage

// File: rtl/lcd_sequencer_if.sv
// Custom-instruction handshake plus LCD pin bundle for the sequencer.
interface lcd_sequencer_if;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic        done;
    logic [31:0] result;
    logic        busy;
    logic        rw;
    logic        en;
    logic        rs;
    logic [7:0]  db;

    modport master (
        output clk_en, start, dataa, datab,
        input  done, result, busy, rw, en, rs, db
    );

    modport slave (
        input  clk_en, start, dataa, datab,
        output done, result, busy, rw, en, rs, db
    );
endinterface

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter shared by every timed state; expire is high while the count is zero.
module lcd_delay_timer #(
    parameter int unsigned CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);
    logic [CNT_W-1:0] cnt;

    // expire is kept equal to (cnt == 0) but held in a flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            expire <= 1'b1;
        end else if (load) begin
            cnt    <= load_val;
            expire <= (load_val == '0);
        end else if (cnt != '0) begin
            cnt    <= cnt - CNT_W'(1);
            expire <= (cnt == CNT_W'(1));
        end
    end
endmodule

// File: rtl/lcd_sequencer.sv
// HD44780 8-bit write sequencer behind a Nios II multi-cycle custom instruction.
// Define LCD_INIT_EN to run the power-up wait and init ROM sequence after reset.
module lcd_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWRUP  = 750000,
    parameter int unsigned T_SETUP  = 4,
    parameter int unsigned T_EN     = 25,
    parameter int unsigned T_HOLD   = 4,
    parameter int unsigned T_EXEC   = 2000,
    parameter int unsigned T_EXEC_L = 82000,
    parameter int unsigned CNT_W    = 20
) (
    input  logic           clk,
    input  logic           rst,
    lcd_sequencer_if.slave bus
);
    state_t           state;
    lcd_write_t       pend;
    logic             pending;
    logic             req_c;
    logic             tmr_load_c;
    logic [CNT_W-1:0] tmr_val_c;
    logic             tmr_expire;
    logic             unused_bits;

`ifdef LCD_INIT_EN
    localparam state_t RST_STATE = ST_PWRUP;
    logic [IDX_W-1:0] init_idx;
    logic             init_done;
    logic             pwr_started;
`else
    localparam state_t RST_STATE = ST_IDLE;
    logic             unused_cfg;
    assign unused_cfg = ^CNT_W'(T_PWRUP);
`endif

    assign unused_bits = ^{bus.dataa[31:1], bus.datab[31:8]};
    assign req_c       = bus.clk_en & bus.start;
    assign bus.rw      = 1'b0;
    assign bus.busy    = (state != ST_IDLE) | pending;

    // Reload the timer on entry to each timed state with its duration minus one
    always_comb begin
        tmr_load_c = 1'b0;
        tmr_val_c  = '0;
        case (state)
`ifdef LCD_INIT_EN
            ST_PWRUP: if (!pwr_started) begin
                tmr_load_c = 1'b1;
                tmr_val_c  = CNT_W'(T_PWRUP - 2);
            end
`endif
            ST_LOAD: begin
                tmr_load_c = 1'b1;
                tmr_val_c  = CNT_W'(T_SETUP - 1);
            end
            ST_SETUP: if (tmr_expire) begin
                tmr_load_c = 1'b1;
                tmr_val_c  = CNT_W'(T_EN - 1);
            end
            ST_PULSE: if (tmr_expire) begin
                tmr_load_c = 1'b1;
                tmr_val_c  = CNT_W'(T_HOLD - 1);
            end
            ST_HOLD: if (tmr_expire) begin
                tmr_load_c = 1'b1;
                tmr_val_c  = is_long_exec(bus.rs, bus.db) ? CNT_W'(T_EXEC_L - 1)
                                                          : CNT_W'(T_EXEC - 1);
            end
            default: ;
        endcase
    end

    lcd_delay_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RST_STATE;
            pend       <= '0;
            pending    <= 1'b0;
            bus.en     <= 1'b0;
            bus.rs     <= 1'b0;
            bus.db     <= 8'h00;
            bus.done   <= 1'b0;
            bus.result <= '0;
`ifdef LCD_INIT_EN
            init_idx    <= '0;
            init_done   <= 1'b0;
            pwr_started <= 1'b0;
`endif
        end else begin
            bus.done   <= 1'b0;
            bus.result <= '0;
            // One-deep request slot; a second request while full is dropped
            if (req_c && !pending) begin
                pending <= 1'b1;
                pend    <= {bus.dataa[0], bus.datab[7:0]};
            end
            case (state)
                ST_IDLE: if (pending || req_c) state <= ST_LOAD;
`ifdef LCD_INIT_EN
                ST_PWRUP: begin
                    if (!pwr_started)   pwr_started <= 1'b1;
                    else if (tmr_expire) state      <= ST_LOAD;
                end
`endif
                ST_LOAD: begin
`ifdef LCD_INIT_EN
                    if (!init_done) begin
                        bus.rs <= 1'b0;
                        bus.db <= init_byte(init_idx);
                    end else
`endif
                    begin
                        bus.rs <= pend.rs;
                        bus.db <= pend.db;
                    end
                    state <= ST_SETUP;
                end
                ST_SETUP: if (tmr_expire) begin
                    bus.en <= 1'b1;
                    state  <= ST_PULSE;
                end
                ST_PULSE: if (tmr_expire) begin
                    bus.en <= 1'b0;
                    state  <= ST_HOLD;
                end
                ST_HOLD: if (tmr_expire) state <= ST_EXEC;
                ST_EXEC: if (tmr_expire) begin
`ifdef LCD_INIT_EN
                    if (!init_done) begin
                        if (init_idx == IDX_W'(INIT_LEN - 1)) begin
                            init_done <= 1'b1;
                            state     <= (pending || req_c) ? ST_LOAD : ST_IDLE;
                        end else begin
                            init_idx <= init_idx + IDX_W'(1);
                            state    <= ST_LOAD;
                        end
                    end else
`endif
                    begin
                        bus.done   <= 1'b1;
                        bus.result <= {24'h0, bus.db};
                        pending    <= req_c;
                        if (req_c) pend <= {bus.dataa[0], bus.datab[7:0]};
                        state      <= req_c ? ST_LOAD : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_sequencer.sv
// Randomised directed bench for lcd_sequencer against a timeline model of LCD bus writes.
// Expectations follow LCD_INIT_EN the same way the design does.
module tb_lcd_sequencer;
    localparam int unsigned T_PWRUP  = 20;
    localparam int unsigned T_SETUP  = 2;
    localparam int unsigned T_EN     = 3;
    localparam int unsigned T_HOLD   = 2;
    localparam int unsigned T_EXEC   = 5;
    localparam int unsigned T_EXEC_L = 12;

    typedef struct packed { logic rs; logic [7:0] db; logic [31:0] t; logic [31:0] w; } wr_t;
    typedef struct packed { logic rs; logic [7:0] db; logic [31:0] t; } ev_t;
    typedef struct packed { logic [31:0] res; logic [31:0] t; } dn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] cyc = '0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    wr_t wr_q[$];
    dn_t done_q[$];
    ev_t exp_w[$];
    dn_t exp_d[$];
    logic [31:0] busy_fall = '0;
    logic en_q = 1'b0, busy_q = 1'b0, r_rs = 1'b0;
    logic [7:0] r_db = '0;
    logic [31:0] r_t = '0;

    lcd_sequencer_if bus ();

    lcd_sequencer #(
        .T_PWRUP(T_PWRUP), .T_SETUP(T_SETUP), .T_EN(T_EN), .T_HOLD(T_HOLD),
        .T_EXEC(T_EXEC), .T_EXEC_L(T_EXEC_L), .CNT_W(20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: records every en pulse, every done cycle and the last busy fall
    always @(negedge clk) begin
        if (bus.en && !en_q) begin
            r_rs = bus.rs; r_db = bus.db; r_t = cyc;
        end
        if (!bus.en && en_q) begin
            if (!rst) begin
                check("hold_rs", 32'(bus.rs), 32'(r_rs));
                check("hold_db", 32'(bus.db), 32'(r_db));
            end
            wr_q.push_back({r_rs, r_db, r_t, cyc - r_t});
        end
        if (bus.done) done_q.push_back({bus.result, cyc});
        if (busy_q && !bus.busy) busy_fall = cyc;
        en_q = bus.en;
        busy_q = bus.busy;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        wr_q.delete(); done_q.delete(); exp_w.delete(); exp_d.delete();
        busy_fall = '0;
    endtask

    function automatic int unsigned exec_cycles(input logic r, input logic [7:0] d);
        return (!r && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? T_EXEC_L : T_EXEC;
    endfunction

    // Expected timeline of one write whose LOAD cycle is at 'load'
    task automatic model_host(input logic r, input logic [7:0] d, input int unsigned load,
                              output int unsigned t_done);
        exp_w.push_back({r, d, 32'(load + 1 + T_SETUP)});
        t_done = load + 1 + T_SETUP + T_EN + T_HOLD + exec_cycles(r, d);
        exp_d.push_back({{24'h0, d}, 32'(t_done)});
    endtask

    task automatic model_init(input int unsigned t0, output int unsigned t_end);
        logic [7:0] seq [6];
        int unsigned t;
        seq = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
        t = t0 + T_PWRUP;
        for (int i = 0; i < 6; i++) begin
            exp_w.push_back({1'b0, seq[i], 32'(t + 1 + T_SETUP)});
            t += 1 + T_SETUP + T_EN + T_HOLD + exec_cycles(1'b0, seq[i]);
        end
        t_end = t;
    endtask

    task automatic issue(input logic r, input logic [7:0] d, output int unsigned s);
        logic [31:0] ja, jb;
        ja = $urandom; jb = $urandom;
        s = cyc;
        bus.clk_en = 1'b1; bus.start = 1'b1;
        bus.dataa = {ja[31:1], r}; bus.datab = {jb[31:8], d};
        tick();
        bus.start = 1'b0; bus.clk_en = 1'($urandom_range(0, 1));
        bus.dataa = $urandom; bus.datab = $urandom;
    endtask

    task automatic verify(input int unsigned t_end, input int unsigned exp_bf);
        while (cyc < t_end) tick();
        check("n_writes", 32'(wr_q.size()), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < wr_q.size(); i++) begin
            check($sformatf("w%0d_rs", i), 32'(wr_q[i].rs), 32'(exp_w[i].rs));
            check($sformatf("w%0d_db", i), 32'(wr_q[i].db), 32'(exp_w[i].db));
            check($sformatf("w%0d_en_rise", i), wr_q[i].t, exp_w[i].t);
            check($sformatf("w%0d_en_width", i), wr_q[i].w, 32'(T_EN));
        end
        check("n_done", 32'(done_q.size()), 32'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < done_q.size(); i++) begin
            check($sformatf("d%0d_result", i), done_q[i].res, exp_d[i].res);
            check($sformatf("d%0d_time", i), done_q[i].t, exp_d[i].t);
        end
        check("busy_fall", busy_fall, 32'(exp_bf));
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_result", bus.result, 32'd0);
        clear_all();
    endtask

    task automatic do_reset(output int unsigned t0);
        rst = 1'b1;
        bus.clk_en = 1'b0; bus.start = 1'b0;
        repeat (2) tick();
        clear_all();
        rst = 1'b0;
        t0 = cyc;
    endtask

    initial begin
        int unsigned t0, s, s2, e, e2, n_skip;
        logic [8:0] dir_tab [6];
        logic r;
        logic [7:0] d;
        logic busy_rst;
        bus.clk_en = 1'b0; bus.start = 1'b0; bus.dataa = '0; bus.datab = '0;
`ifdef LCD_INIT_EN
        busy_rst = 1'b1;
`else
        busy_rst = 1'b0;
`endif
        repeat (2) tick();
        check("rst_en", 32'(bus.en), 32'd0);
        check("rst_rs", 32'(bus.rs), 32'd0);
        check("rst_db", 32'(bus.db), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_rw", 32'(bus.rw), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'(busy_rst));
        do_reset(t0);
`ifdef LCD_INIT_EN
        model_init(t0, e);
        verify(e + 2, e);
`else
        tick();
        issue(1'b1, 8'h5A, s);
        model_host(1'b1, 8'h5A, s + 1, e);
        verify(e + 2, e);
`endif
        // Directed writes: data, long and short commands
        dir_tab = '{9'h141, 9'h001, 9'h080, 9'h002, 9'h003, 9'h101};
        for (int i = 0; i < 6; i++) begin
            issue(dir_tab[i][8], dir_tab[i][7:0], s);
            model_host(dir_tab[i][8], dir_tab[i][7:0], s + 1, e);
            verify(e + 2, e);
        end

        // start without clk_en is not a request
        bus.clk_en = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        verify(cyc + 15, 0);

        // New request in the done cycle is accepted
        issue(1'b1, 8'h31, s);
        model_host(1'b1, 8'h31, s + 1, e);
        while (cyc < e) tick();
        check("chain_done_seen", 32'(bus.done), 32'd1);
        issue(1'b0, 8'h01, s2);
        model_host(1'b0, 8'h01, s2 + 1, e2);
        verify(e2 + 2, e2);

        // Random writes, some with an extra request while pending (must be dropped)
        for (int i = 0; i < 12; i++) begin
            n_skip = $urandom_range(0, 3);
            repeat (n_skip) tick();
            r = 1'($urandom_range(0, 1));
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
            issue(r, d, s);
            model_host(r, d, s + 1, e);
            if ($urandom_range(0, 1) == 1) begin
                repeat (2) tick();
                issue(~r, ~d, s2);
            end
            verify(e + 2, e);
        end

`ifdef LCD_INIT_EN
        // Request during power-up wait is held until init completes
        do_reset(t0);
        repeat (5) tick();
        issue(1'b1, 8'hC3, s);
        model_init(t0, e);
        model_host(1'b1, 8'hC3, e, e2);
        verify(e2 + 2, e2);
`endif

        // Reset in the middle of an en pulse aborts the write
        issue(1'b1, 8'h55, s);
        while (cyc < s + 2 + T_SETUP + 1) tick();
        check("pulse_en_high", 32'(bus.en), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_en", 32'(bus.en), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        repeat (2) tick();
        check("abort_no_done", 32'(done_q.size()), 32'd0);
        clear_all();
        rst = 1'b0;
        t0 = cyc;
`ifdef LCD_INIT_EN
        model_init(t0, e);
        verify(e + 2, e);
`else
        verify(t0 + 20, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
